// File: rtl/local_history_btb_predictor.sv
// Two-level local-history branch predictor with a direct-mapped BTB.
// Per-index BHRs select a 2-bit counter in that index's PHT row; outputs are registered.
module local_history_btb_predictor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int HASH_WIDTH     = 4,
  parameter int HISTORY_LENGTH = 4
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  IFPD_predict_en,
  input  logic [ADDR_WIDTH-1:0] IFPD_pc,
  input  logic                  IFPD_feedback_en,
  input  logic [ADDR_WIDTH-1:0] IFPD_feedback_pc,
  input  logic                  IFPD_branch_result,
  input  logic [ADDR_WIDTH-1:0] IFPD_branch_target,
  output logic                  PDIF_predict_valid,
  output logic                  PDIF_predict_result,
  output logic [ADDR_WIDTH-1:0] PDIF_predict_target,
  output logic                  PDIF_btb_hit
);

  localparam int HASH_SIZE = 2 ** HASH_WIDTH;
  localparam int PHT_SIZE  = 2 ** HISTORY_LENGTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - HASH_WIDTH - 2;

  // Handshake: a request is taken on any edge with IFPD_predict_en & Sys_rdy;
  // PDIF_predict_valid pulses high for exactly the following cycle, with no backpressure.

  logic [1:0]                pht        [HASH_SIZE][PHT_SIZE];
  logic [HISTORY_LENGTH-1:0] bhr        [HASH_SIZE];
  logic                      btb_valid  [HASH_SIZE];
  logic [TAG_WIDTH-1:0]      btb_tag    [HASH_SIZE];
  logic [ADDR_WIDTH-1:0]     btb_target [HASH_SIZE];

  logic [HASH_WIDTH-1:0]     pred_idx;
  logic [TAG_WIDTH-1:0]      pred_tag;
  logic [HISTORY_LENGTH-1:0] pred_hist;
  logic [1:0]                pred_ctr;
  logic                      pred_hit;

  logic [HASH_WIDTH-1:0]     fb_idx;
  logic [TAG_WIDTH-1:0]      fb_tag;
  logic [HISTORY_LENGTH-1:0] fb_hist;
  logic [1:0]                fb_ctr;
  logic [1:0]                fb_ctr_next;

  logic                      do_predict;
  logic                      do_feedback;
  logic                      unused_pc_bits;

  assign do_predict  = IFPD_predict_en & Sys_rdy;
  assign do_feedback = IFPD_feedback_en & Sys_rdy;

  assign pred_idx  = IFPD_pc[HASH_WIDTH+1:2];
  assign pred_tag  = IFPD_pc[ADDR_WIDTH-1:HASH_WIDTH+2];
  assign pred_hist = bhr[pred_idx];
  assign pred_ctr  = pht[pred_idx][pred_hist];
  assign pred_hit  = btb_valid[pred_idx] & (btb_tag[pred_idx] == pred_tag);

  assign fb_idx  = IFPD_feedback_pc[HASH_WIDTH+1:2];
  assign fb_tag  = IFPD_feedback_pc[ADDR_WIDTH-1:HASH_WIDTH+2];
  assign fb_hist = bhr[fb_idx];
  assign fb_ctr  = pht[fb_idx][fb_hist];

  assign unused_pc_bits = ^{IFPD_pc[1:0], IFPD_feedback_pc[1:0]};

  always_comb begin
    fb_ctr_next = fb_ctr;
    if (IFPD_branch_result) begin
      if (fb_ctr != 2'b11) fb_ctr_next = fb_ctr + 2'b01;
    end else begin
      if (fb_ctr != 2'b00) fb_ctr_next = fb_ctr - 2'b01;
    end
  end

  // Table state: all reads above see pre-update values, so a same-cycle
  // predict on the feedback index gets the old history and counter.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      for (int e = 0; e < HASH_SIZE; e++) begin
        for (int k = 0; k < PHT_SIZE; k++) pht[e][k] <= 2'b01;
        bhr[e]        <= '0;
        btb_valid[e]  <= 1'b0;
        btb_tag[e]    <= '0;
        btb_target[e] <= '0;
      end
    end else if (do_feedback) begin
      pht[fb_idx][fb_hist] <= fb_ctr_next;
      bhr[fb_idx]          <= {fb_hist[HISTORY_LENGTH-2:0], IFPD_branch_result};
      if (IFPD_branch_result) begin
        btb_valid[fb_idx]  <= 1'b1;
        btb_tag[fb_idx]    <= fb_tag;
        btb_target[fb_idx] <= IFPD_branch_target;
      end
    end
  end

  // Outputs: result/target/hit hold their last values when no request is taken.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      PDIF_predict_valid  <= 1'b0;
      PDIF_predict_result <= 1'b0;
      PDIF_predict_target <= '0;
      PDIF_btb_hit        <= 1'b0;
    end else if (do_predict) begin
      PDIF_predict_valid  <= 1'b1;
      PDIF_predict_result <= pred_ctr[1] & pred_hit;
      PDIF_predict_target <= pred_hit ? btb_target[pred_idx] : IFPD_pc + ADDR_WIDTH'(4);
      PDIF_btb_hit        <= pred_hit;
    end else begin
      PDIF_predict_valid  <= 1'b0;
    end
  end

endmodule
